// File: rtl/tproc_pkg.sv
`default_nettype none
// =====================================================================
// Module : tproc_pkg
// Brief  : Shared opcodes, widths and dispatcher FSM encoding.
// Rev    : 1.0
// =====================================================================
package tproc_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 64;
  localparam int IDX_W   = 5;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LD_W = 8'h01;
  localparam logic [7:0] OP_CMP  = 8'h02;
  localparam logic [7:0] OP_ST   = 8'h03;
  localparam logic [7:0] OP_LD_F = 8'h04;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_RECV     = 3'd2,
    ST_DISPATCH = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  function automatic logic [7:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_dispatch_if.sv
`default_nettype none
// =====================================================================
// Module : instr_dispatch_if
// Brief  : Control, fetch and unit-handshake bundle of the dispatcher.
// Rev    : 1.0
// =====================================================================
interface instr_dispatch_if;
  import tproc_pkg::*;

  logic               start;
  logic [ADDR_W-1:0]  base_addr;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_enable;
  logic [INSTR_W-1:0] in_instr;
  logic [IDX_W-1:0]   in_instr_addr;
  logic               in_instr_valid;
  logic               ld_valid;
  logic               ld_ready;
  logic               cp_valid;
  logic               cp_ready;
  logic               st_valid;
  logic               st_ready;
  logic [INSTR_W-1:0] disp_instr;
  logic               busy;
  logic               done;
  logic               err_overflow;
  logic               err_opcode;

  modport master (
    output start, base_addr, in_instr, in_instr_addr, in_instr_valid,
           ld_ready, cp_ready, st_ready,
    input  fetch_addr, fetch_enable, ld_valid, cp_valid, st_valid,
           disp_instr, busy, done, err_overflow, err_opcode
  );

  modport slave (
    input  start, base_addr, in_instr, in_instr_addr, in_instr_valid,
           ld_ready, cp_ready, st_ready,
    output fetch_addr, fetch_enable, ld_valid, cp_valid, st_valid,
           disp_instr, busy, done, err_overflow, err_opcode
  );

endinterface
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// =====================================================================
// Module : instr_fifo
// Brief  : Synchronous instruction buffer with flush; push/pop may coincide.
// Rev    : 1.0
// =====================================================================
module instr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  input  wire logic             i_flush,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  // A pop in the same cycle frees the slot a push into a full buffer needs
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_dispatch.sv
`default_nettype none
// =====================================================================
// Module : instr_dispatch
// Brief  : Fetches instruction bursts and dispatches them in order to units.
// Rev    : 1.0
// =====================================================================
module instr_dispatch
  import tproc_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 16
) (
  input wire logic         clk,
  input wire logic         rst,
  instr_dispatch_if.slave  bus
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_fetch_addr;
  logic [CW-1:0]      r_beat_cnt;
  logic               r_err_overflow;
  logic               r_err_opcode;

  logic [INSTR_W-1:0] w_head;
  logic [7:0]         w_op;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  logic               w_ld_valid;
  logic               w_cp_valid;
  logic               w_st_valid;
  logic               w_bad_op;
  logic               w_overflow;
  logic               w_last_beat;
  logic               w_disp_active;
  logic               w_unused;

  // Beat index is informational; beats are buffered in arrival order
  assign w_unused      = ^bus.in_instr_addr;
  assign w_op          = opcode_of(w_head);
  assign w_last_beat   = (r_beat_cnt == CW'(BURST_LEN - 1));
  assign w_disp_active = (r_state == ST_DISPATCH) && !w_empty;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (bus.in_instr),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_ld_valid  = 1'b0;
    w_cp_valid  = 1'b0;
    w_st_valid  = 1'b0;
    w_bad_op    = 1'b0;
    w_overflow  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_state_nxt = ST_RECV;
      end
      ST_RECV: begin
        if (bus.in_instr_valid) begin
          w_push     = !w_full;
          w_overflow = w_full;
          if (w_last_beat) begin
            w_state_nxt = ST_DISPATCH;
          end
        end
      end
      ST_DISPATCH: begin
        if (w_empty) begin
          w_state_nxt = ST_REQ;
        end else begin
          case (w_op)
            OP_LD_F, OP_LD_W: begin
              w_ld_valid = 1'b1;
              w_pop      = bus.ld_ready;
            end
            OP_CMP: begin
              w_cp_valid = 1'b1;
              w_pop      = bus.cp_ready;
            end
            OP_ST: begin
              w_st_valid = 1'b1;
              w_pop      = bus.st_ready;
            end
            OP_NOP: begin
              w_pop = 1'b1;
            end
            OP_HALT: begin
              w_pop       = 1'b1;
              w_flush     = 1'b1;
              w_state_nxt = ST_DONE;
            end
            default: begin
              w_pop    = 1'b1;
              w_bad_op = 1'b1;
            end
          endcase
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_addr   <= '0;
      r_beat_cnt     <= '0;
      r_err_overflow <= 1'b0;
      r_err_opcode   <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && bus.start) begin
        r_fetch_addr   <= bus.base_addr;
        r_err_overflow <= 1'b0;
        r_err_opcode   <= 1'b0;
      end
      if ((r_state == ST_RECV) && bus.in_instr_valid) begin
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + CW'(1);
      end
      // Buffer drained without a halt: fetch the next sequential burst
      if ((r_state == ST_DISPATCH) && w_empty) begin
        r_fetch_addr <= r_fetch_addr + ADDR_W'(BURST_LEN);
      end
      if (w_overflow) begin
        r_err_overflow <= 1'b1;
      end
      if (w_bad_op) begin
        r_err_opcode <= 1'b1;
      end
    end
  end

  assign bus.fetch_addr   = r_fetch_addr;
  assign bus.fetch_enable = (r_state == ST_REQ);
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.done         = (r_state == ST_DONE);
  assign bus.ld_valid     = w_ld_valid;
  assign bus.cp_valid     = w_cp_valid;
  assign bus.st_valid     = w_st_valid;
  assign bus.disp_instr   = w_disp_active ? w_head : '0;
  assign bus.err_overflow = r_err_overflow;
  assign bus.err_opcode   = r_err_opcode;

endmodule
`default_nettype wire
